chunked_add_sub: RTL

Parametrised, multi-cycle two's-complement adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock. It accepts operands and an add/subtract select over a valid/ready handshake, holds a registered result with status flags until the consumer takes it, and is the shared arithmetic unit for datapaths too wide for a single-cycle ripple adder.

---
 rtl/chunked_add_sub_pkg.sv | 25 ++
 rtl/chunked_add_sub_chunk_adder.sv | 30 +++
 rtl/chunked_add_sub.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/chunked_add_sub_pkg.sv
// chunked_add_sub shared types and sizing helpers.
// Imported by the top and its chunk adder.
package chunked_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic int nchunk(input int w, input int c);
    return w / c;
  endfunction

  // Counter must be at least one bit even for a single chunk.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;
  localparam int DEF_CNT_W =
    cnt_w(nchunk(DEF_WIDTH, DEF_CHUNK));

endpackage

// File: rtl/chunked_add_sub_chunk_adder.sv
// CHUNK-bit ripple of full adders.
// Exposes the carry into the top bit for overflow.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             ctop_o
);

  logic [CHUNK:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i])
               | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = c[CHUNK];
  assign ctop_o = c[CHUNK-1];

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle add/sub: WIDTH bits, CHUNK bits per clock.
// Result and flags held until the consumer takes them.
module chunked_add_sub
  import chunked_add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] OpX,
  input  logic [WIDTH-1:0] OpY,
  input  logic             Sub,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             Negative
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_w(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH ||
      (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("chunked_add_sub: bad WIDTH/CHUNK");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             n_q, n_d;

  logic [CHUNK-1:0] xa, yb, sum;
  logic             cout, ctop;
  logic             last;
  int               base;

  always_comb begin
    base = int'(cnt_q) * CHUNK;
    xa   = x_q[base +: CHUNK];
    yb   = y_q[base +: CHUNK];
  end

  assign last = (cnt_q == LAST);

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_add (
    .a_i    (xa),
    .b_i    (yb),
    .cin_i  (carry_q),
    .sum_o  (sum),
    .cout_o (cout),
    .ctop_o (ctop)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        if (InValid) begin
          // Subtract as X + ~Y + 1: invert now, seed carry.
          x_d     = OpX;
          y_d     = OpY ^ {WIDTH{Sub}};
          carry_d = Sub;
          cnt_d   = '0;
          res_d   = '0;
          c_d     = 1'b0;
          v_d     = 1'b0;
          z_d     = 1'b0;
          n_d     = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d[base +: CHUNK] = sum;
        carry_d = cout;
        if (last) begin
          cnt_d   = '0;
          c_d     = cout;
          v_d     = cout ^ ctop;
          z_d     = (res_d == '0);
          n_d     = res_d[WIDTH-1];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign InReady  = Reset_n && (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign Result   = res_q;
  assign CarryOut = c_q;
  assign Overflow = v_q;
  assign Zero     = z_q;
  assign Negative = n_q;

endmodule
